// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap controller.
package trap_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COMMIT   = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    // mcause exception codes (interrupt and exception spaces overlap)
    localparam logic [3:0] CODE_MSI     = 4'd3;
    localparam logic [3:0] CODE_MTI     = 4'd7;
    localparam logic [3:0] CODE_MEI     = 4'd11;
    localparam logic [3:0] CODE_ILLEGAL = 4'd2;
    localparam logic [3:0] CODE_ECALL   = 4'd11;

    // mtvec.MODE encodings; anything other than vectored behaves as direct
    localparam logic [1:0] MTVEC_DIRECT   = 2'd0;
    localparam logic [1:0] MTVEC_VECTORED = 2'd1;

    // Pick the highest-priority pending interrupt: MEI > MSI > MTI.
    // Bit order of pend is {mei, mti, msi}.
    function automatic logic [3:0] irq_code(input logic [2:0] pend);
        logic [3:0] code;
        if (pend[2]) begin
            code = CODE_MEI;
        end else if (pend[0]) begin
            code = CODE_MSI;
        end else begin
            code = CODE_MTI;
        end
        return code;
    endfunction

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Two-flop synchronizer for asynchronous interrupt request levels.
module irq_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; second flop gives a clean level
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap controller: takes exceptions, MRET and interrupts at
// commit, updates the trap CSRs for one cycle and redirects fetch.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            exc_valid,
    input  logic [3:0]      exc_code,
    input  logic [XLEN-1:0] exc_pc,
    input  logic [XLEN-1:0] exc_tval,
    input  logic            mret_valid,
    input  logic            int_window,
    input  logic [XLEN-1:0] int_pc,
    input  logic            irq_msip,
    input  logic            irq_mtip,
    input  logic            irq_meip,
    output logic            evt_ready,
    output logic            flush,
    output logic            redir_valid,
    output logic [XLEN-1:0] redir_pc,
    input  logic            redir_ready,
    input  logic            csr_rd_mstatus_mie,
    input  logic            csr_rd_mstatus_mpie,
    input  logic            csr_rd_mie_msie,
    input  logic            csr_rd_mie_mtie,
    input  logic            csr_rd_mie_meie,
    input  logic [XLEN-3:0] csr_rd_mtvec_base,
    input  logic [1:0]      csr_rd_mtvec_mode,
    input  logic [XLEN-1:0] csr_rd_mepc_mepc,
    output logic            ent_trap,
    output logic            ext_trap,
    output logic            csr_wr_mstatus_mie,
    output logic            csr_wr_mstatus_mpie,
    output logic [XLEN-1:0] csr_wr_mepc_mepc,
    output logic [XLEN-1:0] csr_wr_mtval_mtval,
    output logic [XLEN-2:0] csr_wr_mcause_exception_code,
    output logic            csr_wr_mcause_interrupt,
    output logic            csr_set_mip_msip,
    output logic            csr_set_mip_mtip,
    output logic            csr_set_mip_meip
);

    state_t          state;
    state_t          state_next;
    logic [2:0]      irq_raw;
    logic [2:0]      irq_lvl;
    logic [2:0]      irq_pend;
    logic            take_exc;
    logic            take_mret;
    logic            take_int;
    logic            cap_mret;
    logic            cap_int;
    logic [XLEN-2:0] cap_code;
    logic [XLEN-1:0] cap_pc;
    logic [XLEN-1:0] cap_tval;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] redir_pc_q;

    assign irq_raw = {irq_meip, irq_mtip, irq_msip};

    irq_sync #(.WIDTH(3)) u_irq_sync (
        .clk   (clk),
        .rst_b (rst_b),
        .d     (irq_raw),
        .q     (irq_lvl)
    );

    assign csr_set_mip_msip = irq_lvl[0];
    assign csr_set_mip_mtip = irq_lvl[1];
    assign csr_set_mip_meip = irq_lvl[2];

    assign irq_pend = irq_lvl
                    & {csr_rd_mie_meie, csr_rd_mie_mtie, csr_rd_mie_msie}
                    & {3{csr_rd_mstatus_mie}};

    assign redir_pc = redir_valid ? redir_pc_q : '0;

    // Redirect target: mepc for MRET, otherwise mtvec base with vectoring for interrupts
    always_comb begin
        target = {csr_rd_mtvec_base, 2'b00};
        if (cap_mret) begin
            target = csr_rd_mepc_mepc;
        end else if (cap_int && (csr_rd_mtvec_mode == MTVEC_VECTORED)) begin
            target = {csr_rd_mtvec_base, 2'b00} + {cap_code[XLEN-3:0], 2'b00};
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic, event arbitration and CSR write strobes
    always_comb begin
        state_next                   = state;
        evt_ready                    = 1'b0;
        flush                        = 1'b0;
        redir_valid                  = 1'b0;
        ent_trap                     = 1'b0;
        ext_trap                     = 1'b0;
        csr_wr_mstatus_mie           = 1'b0;
        csr_wr_mstatus_mpie          = 1'b0;
        csr_wr_mepc_mepc             = '0;
        csr_wr_mtval_mtval           = '0;
        csr_wr_mcause_exception_code = '0;
        csr_wr_mcause_interrupt      = 1'b0;
        take_exc                     = 1'b0;
        take_mret                    = 1'b0;
        take_int                     = 1'b0;
        case (state)
            ST_IDLE: begin
                evt_ready = 1'b1;
                take_exc  = exc_valid;
                take_mret = !exc_valid && mret_valid;
                take_int  = !exc_valid && !mret_valid && int_window && (|irq_pend);
                if (take_exc || take_mret || take_int) begin
                    state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                flush = 1'b1;
                if (cap_mret) begin
                    ext_trap            = 1'b1;
                    csr_wr_mstatus_mie  = csr_rd_mstatus_mpie;
                    csr_wr_mstatus_mpie = 1'b1;
                end else begin
                    ent_trap                     = 1'b1;
                    csr_wr_mstatus_mie           = 1'b0;
                    csr_wr_mstatus_mpie          = csr_rd_mstatus_mie;
                    csr_wr_mepc_mepc             = cap_pc;
                    csr_wr_mtval_mtval           = cap_tval;
                    csr_wr_mcause_exception_code = cap_code;
                    csr_wr_mcause_interrupt      = cap_int;
                end
                state_next = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                flush       = 1'b1;
                redir_valid = 1'b1;
                if (redir_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Capture the winning event so CSR writes use values from the event cycle
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            cap_mret <= 1'b0;
            cap_int  <= 1'b0;
            cap_code <= '0;
            cap_pc   <= '0;
            cap_tval <= '0;
        end else if (take_exc) begin
            cap_mret <= 1'b0;
            cap_int  <= 1'b0;
            cap_code <= {{(XLEN-5){1'b0}}, exc_code};
            cap_pc   <= exc_pc;
            cap_tval <= exc_tval;
        end else if (take_mret) begin
            cap_mret <= 1'b1;
            cap_int  <= 1'b0;
            cap_code <= '0;
            cap_pc   <= '0;
            cap_tval <= '0;
        end else if (take_int) begin
            cap_mret <= 1'b0;
            cap_int  <= 1'b1;
            cap_code <= {{(XLEN-5){1'b0}}, irq_code(irq_pend)};
            cap_pc   <= int_pc;
            cap_tval <= '0;
        end
    end

    // Register the redirect target during COMMIT so redir_pc stays stable
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            redir_pc_q <= '0;
        end else if (state == ST_COMMIT) begin
            redir_pc_q <= target;
        end
    end

endmodule

// File: tb/tb_trap_ctrl.sv
// Self-checking bench for trap_ctrl: directed scenarios plus a cycle model.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    localparam int XLEN = 32;
    localparam int PH_WAIT   = 0;
    localparam int PH_UPDATE = 1;
    localparam int PH_REDIR  = 2;

    logic            clk = 1'b0;
    logic            rst_b = 1'b1;
    logic            exc_valid = 1'b0;
    logic [3:0]      exc_code = '0;
    logic [XLEN-1:0] exc_pc = '0;
    logic [XLEN-1:0] exc_tval = '0;
    logic            mret_valid = 1'b0;
    logic            int_window = 1'b0;
    logic [XLEN-1:0] int_pc = '0;
    logic            irq_msip = 1'b0;
    logic            irq_mtip = 1'b0;
    logic            irq_meip = 1'b0;
    logic            redir_ready = 1'b0;
    logic            csr_rd_mstatus_mie = 1'b0;
    logic            csr_rd_mstatus_mpie = 1'b0;
    logic            csr_rd_mie_msie = 1'b0;
    logic            csr_rd_mie_mtie = 1'b0;
    logic            csr_rd_mie_meie = 1'b0;
    logic [XLEN-3:0] csr_rd_mtvec_base = '0;
    logic [1:0]      csr_rd_mtvec_mode = '0;
    logic [XLEN-1:0] csr_rd_mepc_mepc = '0;

    logic            evt_ready;
    logic            flush;
    logic            redir_valid;
    logic [XLEN-1:0] redir_pc;
    logic            ent_trap;
    logic            ext_trap;
    logic            csr_wr_mstatus_mie;
    logic            csr_wr_mstatus_mpie;
    logic [XLEN-1:0] csr_wr_mepc_mepc;
    logic [XLEN-1:0] csr_wr_mtval_mtval;
    logic [XLEN-2:0] csr_wr_mcause_exception_code;
    logic            csr_wr_mcause_interrupt;
    logic            csr_set_mip_msip;
    logic            csr_set_mip_mtip;
    logic            csr_set_mip_meip;

    int n_checks = 0;
    int n_pass   = 0;
    logic check_en = 1'b0;

    trap_ctrl #(.XLEN(XLEN)) dut (
        .clk                          (clk),
        .rst_b                        (rst_b),
        .exc_valid                    (exc_valid),
        .exc_code                     (exc_code),
        .exc_pc                       (exc_pc),
        .exc_tval                     (exc_tval),
        .mret_valid                   (mret_valid),
        .int_window                   (int_window),
        .int_pc                       (int_pc),
        .irq_msip                     (irq_msip),
        .irq_mtip                     (irq_mtip),
        .irq_meip                     (irq_meip),
        .evt_ready                    (evt_ready),
        .flush                        (flush),
        .redir_valid                  (redir_valid),
        .redir_pc                     (redir_pc),
        .redir_ready                  (redir_ready),
        .csr_rd_mstatus_mie           (csr_rd_mstatus_mie),
        .csr_rd_mstatus_mpie          (csr_rd_mstatus_mpie),
        .csr_rd_mie_msie              (csr_rd_mie_msie),
        .csr_rd_mie_mtie              (csr_rd_mie_mtie),
        .csr_rd_mie_meie              (csr_rd_mie_meie),
        .csr_rd_mtvec_base            (csr_rd_mtvec_base),
        .csr_rd_mtvec_mode            (csr_rd_mtvec_mode),
        .csr_rd_mepc_mepc             (csr_rd_mepc_mepc),
        .ent_trap                     (ent_trap),
        .ext_trap                     (ext_trap),
        .csr_wr_mstatus_mie           (csr_wr_mstatus_mie),
        .csr_wr_mstatus_mpie          (csr_wr_mstatus_mpie),
        .csr_wr_mepc_mepc             (csr_wr_mepc_mepc),
        .csr_wr_mtval_mtval           (csr_wr_mtval_mtval),
        .csr_wr_mcause_exception_code (csr_wr_mcause_exception_code),
        .csr_wr_mcause_interrupt      (csr_wr_mcause_interrupt),
        .csr_set_mip_msip             (csr_set_mip_msip),
        .csr_set_mip_mtip             (csr_set_mip_mtip),
        .csr_set_mip_meip             (csr_set_mip_meip)
    );

    always #5 clk = ~clk;

    // One comparison: count it, report mismatches
    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Reference model: what the controller must be doing, by phase of the
    // current transaction (waiting for event / CSR update cycle / redirect).
    // ------------------------------------------------------------------
    int          m_phase;
    logic        m_mret;
    logic        m_int;
    logic [3:0]  m_code;
    logic [31:0] m_pc;
    logic [31:0] m_tval;
    logic [31:0] m_target;
    logic [2:0]  m_sample_prev;
    logic [2:0]  m_lvl;

    function automatic logic [2:0] model_pending(input logic [2:0] lvl);
        logic [2:0] en;
        en = {csr_rd_mie_meie, csr_rd_mie_mtie, csr_rd_mie_msie};
        return csr_rd_mstatus_mie ? (lvl & en) : 3'b000;
    endfunction

    function automatic logic [3:0] model_int_code(input logic [2:0] pend);
        if (pend[2]) return 4'd11;
        if (pend[0]) return 4'd3;
        return 4'd7;
    endfunction

    function automatic logic [31:0] model_target(input logic mret, input logic intr, input logic [3:0] code);
        logic [31:0] t;
        if (mret) return csr_rd_mepc_mepc;
        t = {csr_rd_mtvec_base, 2'b00};
        if (intr && csr_rd_mtvec_mode == 2'd1) t = t + 32'(code) * 32'd4;
        return t;
    endfunction

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            m_phase       <= PH_WAIT;
            m_mret        <= 1'b0;
            m_int         <= 1'b0;
            m_code        <= '0;
            m_pc          <= '0;
            m_tval        <= '0;
            m_target      <= '0;
            m_sample_prev <= '0;
            m_lvl         <= '0;
        end else begin
            m_sample_prev <= {irq_meip, irq_mtip, irq_msip};
            m_lvl         <= m_sample_prev;
            case (m_phase)
                PH_WAIT: begin
                    if (exc_valid) begin
                        m_mret <= 1'b0; m_int <= 1'b0; m_code <= exc_code;
                        m_pc <= exc_pc; m_tval <= exc_tval; m_phase <= PH_UPDATE;
                    end else if (mret_valid) begin
                        m_mret <= 1'b1; m_int <= 1'b0; m_phase <= PH_UPDATE;
                    end else if (int_window && model_pending(m_lvl) != 3'b000) begin
                        m_mret <= 1'b0; m_int <= 1'b1; m_code <= model_int_code(model_pending(m_lvl));
                        m_pc <= int_pc; m_tval <= '0; m_phase <= PH_UPDATE;
                    end
                end
                PH_UPDATE: begin
                    m_target <= model_target(m_mret, m_int, m_code);
                    m_phase  <= PH_REDIR;
                end
                default: begin
                    if (redir_ready) m_phase <= PH_WAIT;
                end
            endcase
        end
    end

    // Compare the DUT against the model on every falling edge out of reset
    always @(negedge clk) begin
        if (rst_b && check_en) begin
            check_output("cmp.evt_ready", evt_ready, (m_phase == PH_WAIT));
            check_output("cmp.flush", flush, (m_phase != PH_WAIT));
            check_output("cmp.ent_trap", ent_trap, (m_phase == PH_UPDATE && !m_mret));
            check_output("cmp.ext_trap", ext_trap, (m_phase == PH_UPDATE && m_mret));
            check_output("cmp.redir_valid", redir_valid, (m_phase == PH_REDIR));
            check_output("cmp.set_mip", {csr_set_mip_meip, csr_set_mip_mtip, csr_set_mip_msip}, m_lvl);
            if (m_phase == PH_UPDATE && !m_mret) begin
                check_output("cmp.mcause_code", csr_wr_mcause_exception_code, m_code);
                check_output("cmp.mcause_int", csr_wr_mcause_interrupt, m_int);
                check_output("cmp.mepc", csr_wr_mepc_mepc, m_pc);
                check_output("cmp.mtval", csr_wr_mtval_mtval, m_tval);
                check_output("cmp.mie_wr", csr_wr_mstatus_mie, 1'b0);
                check_output("cmp.mpie_wr", csr_wr_mstatus_mpie, csr_rd_mstatus_mie);
            end
            if (m_phase == PH_UPDATE && m_mret) begin
                check_output("cmp.mie_wr", csr_wr_mstatus_mie, csr_rd_mstatus_mpie);
                check_output("cmp.mpie_wr", csr_wr_mstatus_mpie, 1'b1);
            end
            if (m_phase == PH_REDIR) begin
                check_output("cmp.redir_pc", redir_pc, m_target);
            end
        end
    end

    // Accept the redirect and confirm return to IDLE
    task automatic finish_redirect(input string tag);
        redir_ready = 1'b1;
        next_cycle();
        redir_ready = 1'b0;
        @(negedge clk);
        check_output({tag, ".back_idle"}, evt_ready, 1'b1);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        // Reset state
        #1 rst_b = 1'b0;
        #2;
        check_output("rst.redir_valid", redir_valid, 1'b0);
        check_output("rst.flush", flush, 1'b0);
        check_output("rst.traps", {ent_trap, ext_trap}, 2'b00);
        check_output("rst.mip", {csr_set_mip_meip, csr_set_mip_mtip, csr_set_mip_msip}, 3'b000);
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        check_en = 1'b1;
        @(negedge clk);
        check_output("rst.evt_ready", evt_ready, 1'b1);

        // Illegal-instruction exception, direct mtvec 0x80000000
        next_cycle();
        csr_rd_mtvec_base = 30'h2000_0000; csr_rd_mtvec_mode = MTVEC_DIRECT;
        csr_rd_mstatus_mie = 1'b1;
        exc_valid = 1'b1; exc_code = CODE_ILLEGAL; exc_pc = 32'h100; exc_tval = 32'hDEAD;
        @(negedge clk);
        check_output("exc.evt_ready", evt_ready, 1'b1);
        next_cycle();
        exc_valid = 1'b0;
        @(negedge clk);
        check_output("exc.ent_trap", ent_trap, 1'b1);
        check_output("exc.ext_trap", ext_trap, 1'b0);
        check_output("exc.mcause", {csr_wr_mcause_interrupt, csr_wr_mcause_exception_code}, 64'd2);
        check_output("exc.mepc", csr_wr_mepc_mepc, 64'h100);
        check_output("exc.mtval", csr_wr_mtval_mtval, 64'hDEAD);
        check_output("exc.mie_wr", csr_wr_mstatus_mie, 1'b0);
        check_output("exc.mpie_wr", csr_wr_mstatus_mpie, 1'b1);
        next_cycle();
        @(negedge clk);
        check_output("exc.redir_valid", redir_valid, 1'b1);
        check_output("exc.redir_pc", redir_pc, 64'h8000_0000);
        check_output("exc.ent_pulse", ent_trap, 1'b0);
        finish_redirect("exc");

        // Timer interrupt, vectored mtvec 0x80000001
        next_cycle();
        csr_rd_mtvec_base = 30'h2000_0000; csr_rd_mtvec_mode = MTVEC_VECTORED;
        csr_rd_mie_mtie = 1'b1; irq_mtip = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_output("mti.mip_mtip", csr_set_mip_mtip, 1'b1);
        next_cycle();
        int_window = 1'b1; int_pc = 32'h200;
        next_cycle();
        int_window = 1'b0;
        @(negedge clk);
        check_output("mti.ent_trap", ent_trap, 1'b1);
        check_output("mti.mcause_int", csr_wr_mcause_interrupt, 1'b1);
        check_output("mti.mcause_code", csr_wr_mcause_exception_code, 64'd7);
        check_output("mti.mepc", csr_wr_mepc_mepc, 64'h200);
        check_output("mti.mtval", csr_wr_mtval_mtval, 64'h0);
        next_cycle();
        @(negedge clk);
        check_output("mti.redir_pc", redir_pc, 64'h8000_001C);
        finish_redirect("mti");
        irq_mtip = 1'b0; csr_rd_mie_mtie = 1'b0;

        // MEI and MSI together: MEI wins; then an exception beats both
        next_cycle();
        csr_rd_mie_meie = 1'b1; csr_rd_mie_msie = 1'b1;
        irq_meip = 1'b1; irq_msip = 1'b1;
        repeat (3) next_cycle();
        int_window = 1'b1; int_pc = 32'h240;
        next_cycle();
        int_window = 1'b0;
        @(negedge clk);
        check_output("mei.mcause_int", csr_wr_mcause_interrupt, 1'b1);
        check_output("mei.mcause_code", csr_wr_mcause_exception_code, 64'd11);
        check_output("mei.mepc", csr_wr_mepc_mepc, 64'h240);
        next_cycle();
        @(negedge clk);
        check_output("mei.redir_pc", redir_pc, 64'h8000_002C);
        finish_redirect("mei");
        next_cycle();
        int_window = 1'b1; int_pc = 32'h280;
        exc_valid = 1'b1; exc_code = CODE_ILLEGAL; exc_pc = 32'h400; exc_tval = 32'h55;
        next_cycle();
        int_window = 1'b0; exc_valid = 1'b0;
        @(negedge clk);
        check_output("excwin.mcause", {csr_wr_mcause_interrupt, csr_wr_mcause_exception_code}, 64'd2);
        check_output("excwin.mepc", csr_wr_mepc_mepc, 64'h400);
        check_output("excwin.mtval", csr_wr_mtval_mtval, 64'h55);
        next_cycle();
        @(negedge clk);
        check_output("excwin.redir_pc", redir_pc, 64'h8000_0000);
        finish_redirect("excwin");
        irq_meip = 1'b0; irq_msip = 1'b0;
        csr_rd_mie_meie = 1'b0; csr_rd_mie_msie = 1'b0;

        // MRET back to mepc 0x300
        next_cycle();
        csr_rd_mstatus_mie = 1'b0; csr_rd_mstatus_mpie = 1'b1; csr_rd_mepc_mepc = 32'h300;
        mret_valid = 1'b1;
        next_cycle();
        mret_valid = 1'b0;
        @(negedge clk);
        check_output("mret.ext_trap", ext_trap, 1'b1);
        check_output("mret.ent_trap", ent_trap, 1'b0);
        check_output("mret.mie_wr", csr_wr_mstatus_mie, 1'b1);
        check_output("mret.mpie_wr", csr_wr_mstatus_mpie, 1'b1);
        next_cycle();
        @(negedge clk);
        check_output("mret.redir_pc", redir_pc, 64'h300);
        finish_redirect("mret");

        // Back-pressure on the redirect with new events arriving meanwhile
        next_cycle();
        exc_valid = 1'b1; exc_code = CODE_ECALL; exc_pc = 32'h500; exc_tval = 32'h0;
        next_cycle();
        exc_valid = 1'b0;
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("hold.redir_valid", redir_valid, 1'b1);
            check_output("hold.redir_pc", redir_pc, 64'h8000_0000);
            check_output("hold.flush", flush, 1'b1);
            check_output("hold.evt_ready", evt_ready, 1'b0);
            next_cycle();
            exc_valid = 1'b1; exc_pc = 32'h600 + 32'(i);
        end
        exc_valid = 1'b0;
        finish_redirect("hold");
        next_cycle();
        @(negedge clk);
        check_output("hold.no_trap", ent_trap, 1'b0);
        check_output("hold.no_flush", flush, 1'b0);

        // Asynchronous reset in the middle of a redirect
        next_cycle();
        exc_valid = 1'b1; exc_code = CODE_ILLEGAL; exc_pc = 32'h700; exc_tval = 32'h1;
        next_cycle();
        exc_valid = 1'b0;
        next_cycle();
        @(negedge clk);
        check_output("arst.pre_redir", redir_valid, 1'b1);
        #2 rst_b = 1'b0;
        #1;
        check_output("arst.redir_valid", redir_valid, 1'b0);
        check_output("arst.flush", flush, 1'b0);
        check_output("arst.redir_pc", redir_pc, 64'h0);
        next_cycle();
        rst_b = 1'b1;
        @(negedge clk);
        check_output("arst.evt_ready", evt_ready, 1'b1);
        check_output("arst.idle_flush", flush, 1'b0);
        next_cycle();
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 Parameter XLEN, default 32: datapath width.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst_b  in  1  reset; asynchronous, active-low.
REQ-004 exc_valid / exc_code / exc_pc / exc_tval  in  1/4/XLEN/XLEN  synchronous exception from commit stage.
REQ-005 mret_valid  in  1  MRET at commit.
REQ-006 int_window / int_pc  in  1/XLEN  commit boundary where an interrupt may be taken; next PC to execute.
REQ-007 irq_msip / irq_mtip / irq_meip  in  1 each  raw asynchronous interrupt levels.
REQ-008 evt_ready  out  1  high only in IDLE; commit stage holds events while low.
REQ-009 flush  out  1  pipeline flush request.
REQ-010 redir_valid / redir_pc / redir_ready  out/out/in  1/XLEN/1  fetch redirect handshake.
REQ-011 csr_rd_mstatus_mie, csr_rd_mstatus_mpie, csr_rd_mie_msie/mtie/meie, csr_rd_mtvec_base[XLEN-3:0], csr_rd_mtvec_mode[1:0], csr_rd_mepc_mepc[XLEN-1:0]  in  CSR field values.
REQ-012 ent_trap, ext_trap, csr_wr_mstatus_mie, csr_wr_mstatus_mpie, csr_wr_mepc_mepc, csr_wr_mtval_mtval, csr_wr_mcause_exception_code[XLEN-2:0], csr_wr_mcause_interrupt, csr_set_mip_msip/mtip/meip  out  CSR field writes.

Function
REQ-013 FSM states: IDLE, COMMIT, REDIRECT; reset state IDLE.
REQ-014 irq_* SHALL pass through a 2-flop synchronizer; csr_set_mip_* SHALL equal the synchronized levels.
REQ-015 Interrupt pending = sync level & matching mie bit & csr_rd_mstatus_mie; priority MEI (11) > MSI (3) > MTI (7).
REQ-016 In IDLE, priority: exc_valid > mret_valid > (int_window & pending); the winner is captured (cause, interrupt flag, pc, tval) and the FSM moves to COMMIT.
REQ-017 Interrupt capture: mepc = int_pc, mtval = 0; exception capture: mepc = exc_pc, mtval = exc_tval, code zero-extended.
REQ-018 COMMIT, trap: ent_trap=1 for exactly one cycle; csr_wr_mstatus_mie=0; csr_wr_mstatus_mpie=csr_rd_mstatus_mie; mepc/mtval/mcause writes = captured values.
REQ-019 COMMIT, MRET: ext_trap=1 for one cycle; csr_wr_mstatus_mie=csr_rd_mstatus_mpie; csr_wr_mstatus_mpie=1.
REQ-020 COMMIT SHALL register the target: MRET -> csr_rd_mepc_mepc; trap -> {base,2'b00}, plus 4*code when mode==1 and interrupt; mode 2/3 treated as direct; arithmetic modulo 2^XLEN.
REQ-021 REDIRECT: redir_valid=1 with redir_pc stable until redir_ready; on handshake -> IDLE next cycle.
REQ-022 flush=1 in COMMIT and REDIRECT, 0 in IDLE.
REQ-023 Latency: event in cycle N -> ent/ext_trap in N+1 -> redir_valid from N+2.
REQ-024 Events presented outside IDLE SHALL be ignored (evt_ready=0).
REQ-025 ent_trap and ext_trap SHALL never both be high.

Reset
REQ-026 On rst_b low (any state, including mid-REDIRECT): FSM=IDLE, synchronizers and captures cleared, all outputs 0 except evt_ready=1 once rst_b deasserts.

Structure
REQ-027 Shared package: FSM state enum, mcause code constants (MSI=3, MTI=7, MEI=11, illegal=2, ecall=11), mtvec mode constants.
REQ-028 One sub-module: irq_sync (2-flop synchronizer, parameterized width).

Verification
REQ-029 exc_valid, exc_code=2, exc_pc=0x100, tval=0xDEAD, mtvec=0x80000000 -> N+1 ent_trap, mcause=2, mepc=0x100, mtval=0xDEAD, mie write 0; redir_pc=0x80000000.
REQ-030 mtvec base 0x20000000 (mtvec=0x80000001), mstatus_mie=1, mie_mtie=1, irq_mtip held, int_window, int_pc=0x200 -> mcause interrupt=1 code 7, mepc=0x200, redir_pc=0x8000001C.
REQ-031 irq_meip and irq_msip asserted together, both enabled -> code 11 taken; same cycle exc_valid -> exception wins.
REQ-032 mret_valid, mepc=0x300, mpie=1 -> ext_trap pulse, mie write 1, mpie write 1, redir_pc=0x300.
REQ-033 redir_ready low 5 cycles -> redir_valid/redir_pc/flush held; new exc_valid ignored.
REQ-034 rst_b pulsed low in REDIRECT -> redir_valid, flush drop asynchronously; IDLE after release.
